// File: rtl/axis_record_unpacker.sv
// -----------------------------------------------------------------------------
// axis_record_unpacker
//
// Splits AXI-Stream beats of C_AXIS_TDATA_WIDTH bits into sorter records of
// C_SORTER_BIT_WIDTH bits and writes them into the sorter input FIFO at one
// record per cycle, record 0 taken from the least significant bits. On the
// tlast beat only the leading records whose first byte is kept are written.
// After the payload of each packet, C_TERM_RECORDS terminator records of value
// C_TERM_VALUE are appended.
//
// Ports
//   s_axis_aclk     clock
//   s_axis_aresetn  asynchronous reset, active low
//   s_axis_tvalid   beat valid
//   s_axis_tready   beat accepted when tvalid & tready
//   s_axis_tdata    beat payload, record 0 in bits [S-1:0]
//   s_axis_tkeep    byte enables, examined only on the tlast beat
//   s_axis_tlast    last beat of packet
//   fifo_full       sorter FIFO full, blocks writes
//   in_fifo_data    record to write
//   in_fifo_en      FIFO write strobe, never high while fifo_full
//   pkt_done        one-cycle pulse after the final write of a packet
//   pkt_rec_count   payload records of the last finished packet
//   busy            state is not IDLE
// -----------------------------------------------------------------------------
module axis_record_unpacker #(
   parameter int                              C_AXIS_TDATA_WIDTH = 512,
   parameter int                              C_SORTER_BIT_WIDTH = 32,
   parameter int                              C_TERM_RECORDS     = 1,
   parameter logic [C_SORTER_BIT_WIDTH-1:0]   C_TERM_VALUE       = '0,
   parameter int                              C_CNT_WIDTH        = 32
) (
   input  logic                              s_axis_aclk,
   input  logic                              s_axis_aresetn,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                              s_axis_tlast,
   input  logic                              fifo_full,
   output logic [C_SORTER_BIT_WIDTH-1:0]     in_fifo_data,
   output logic                              in_fifo_en,
   output logic                              pkt_done,
   output logic [C_CNT_WIDTH-1:0]            pkt_rec_count,
   output logic                              busy
);

   localparam int RECS = C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH;
   localparam int RB   = C_SORTER_BIT_WIDTH / 8;
   localparam int KW   = C_AXIS_TDATA_WIDTH / 8;
   localparam int IW   = $clog2(RECS + 1);
   localparam int TW   = (C_TERM_RECORDS > 1) ? $clog2(C_TERM_RECORDS) : 1;
   localparam logic [TW-1:0] TERM_LAST = TW'((C_TERM_RECORDS > 0) ? (C_TERM_RECORDS - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_TERM = 2'd2
   } state_t;

   state_t                          state_q,         state_d;
   logic [C_AXIS_TDATA_WIDTH-1:0]   beat_q,          beat_d;
   logic                            tlast_q,         tlast_d;
   logic [IW-1:0]                   n_q,             n_d;
   logic [IW-1:0]                   rec_idx_q,       rec_idx_d;
   logic [TW-1:0]                   term_cnt_q,      term_cnt_d;
   logic [C_CNT_WIDTH-1:0]          run_cnt_q,       run_cnt_d;
   logic [C_CNT_WIDTH-1:0]          pkt_rec_count_q, pkt_rec_count_d;
   logic                            pkt_done_q,      pkt_done_d;

   logic                            wr_s;
   logic                            last_rec_s;
   logic                            tready_s;
   logic                            load_s;
   logic [IW-1:0]                   keep_n_s;
   logic [C_CNT_WIDTH-1:0]          load_cnt_s;
   logic                            beat_end_s;
   logic                            to_term_s;
   logic                            finish_s;
   logic [C_CNT_WIDTH-1:0]          finish_cnt_s;

   // Number of leading records whose first byte is kept; stops at the first gap.
   function automatic logic [IW-1:0] lead_recs(input logic [KW-1:0] keep);
      logic [IW-1:0] n;
      logic          run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < RECS; i++) begin
         if (run && keep[i*RB]) begin
            n = n + IW'(1);
         end else begin
            run = 1'b0;
         end
      end
      return n;
   endfunction

   // Handshake, write strobe and packet-boundary decode.
   always_comb begin
      wr_s       = ((state_q == ST_EMIT) || (state_q == ST_TERM)) && !fifo_full;
      last_rec_s = (rec_idx_q == (n_q - IW'(1)));
      case (state_q)
         ST_IDLE: tready_s = 1'b1;
         // Accept the next beat only while writing the final record of a
         // non-last beat so the record stream has no bubble.
         ST_EMIT: tready_s = last_rec_s && !tlast_q && !fifo_full;
         ST_TERM: tready_s = 1'b0;
         default: tready_s = 1'b0;
      endcase
      load_s       = s_axis_tvalid && tready_s;
      keep_n_s     = s_axis_tlast ? lead_recs(s_axis_tkeep) : IW'(RECS);
      // A load in EMIT coincides with a payload write that must be counted.
      load_cnt_s   = (state_q == ST_EMIT) ? (run_cnt_q + C_CNT_WIDTH'(1)) : run_cnt_q;
      beat_end_s   = (state_q == ST_EMIT) && wr_s && last_rec_s;
      to_term_s    = (load_s && (keep_n_s == '0)) || (beat_end_s && tlast_q);
      finish_s     = (to_term_s && (C_TERM_RECORDS == 0)) ||
                     ((state_q == ST_TERM) && wr_s && (term_cnt_q == TERM_LAST));
      finish_cnt_s = (state_q == ST_TERM) ? run_cnt_q : load_cnt_s;
   end

   // Next-state computation for all datapath and control registers.
   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      tlast_d         = tlast_q;
      n_d             = n_q;
      rec_idx_d       = rec_idx_q;
      term_cnt_d      = term_cnt_q;
      run_cnt_d       = run_cnt_q;
      pkt_rec_count_d = pkt_rec_count_q;
      pkt_done_d      = 1'b0;

      if (load_s) begin
         beat_d    = s_axis_tdata;
         tlast_d   = s_axis_tlast;
         n_d       = keep_n_s;
         rec_idx_d = '0;
      end else if ((state_q == ST_EMIT) && wr_s) begin
         beat_d    = beat_q >> C_SORTER_BIT_WIDTH;
         rec_idx_d = rec_idx_q + IW'(1);
      end else begin
         beat_d    = beat_q;
         rec_idx_d = rec_idx_q;
      end

      if (finish_s) begin
         run_cnt_d = '0;
      end else if ((state_q == ST_EMIT) && wr_s) begin
         run_cnt_d = run_cnt_q + C_CNT_WIDTH'(1);
      end else begin
         run_cnt_d = run_cnt_q;
      end

      if (finish_s) begin
         pkt_rec_count_d = finish_cnt_s;
         pkt_done_d      = 1'b1;
      end else begin
         pkt_rec_count_d = pkt_rec_count_q;
         pkt_done_d      = 1'b0;
      end

      if (to_term_s) begin
         term_cnt_d = '0;
      end else if ((state_q == ST_TERM) && wr_s) begin
         term_cnt_d = term_cnt_q + TW'(1);
      end else begin
         term_cnt_d = term_cnt_q;
      end

      if (finish_s) begin
         state_d = ST_IDLE;
      end else if (to_term_s) begin
         state_d = ST_TERM;
      end else if (load_s) begin
         state_d = ST_EMIT;
      end else if (beat_end_s) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers; reset discards any held beat and counts.
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         state_q         <= ST_IDLE;
         beat_q          <= '0;
         tlast_q         <= 1'b0;
         n_q             <= '0;
         rec_idx_q       <= '0;
         term_cnt_q      <= '0;
         run_cnt_q       <= '0;
         pkt_rec_count_q <= '0;
         pkt_done_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         beat_q          <= beat_d;
         tlast_q         <= tlast_d;
         n_q             <= n_d;
         rec_idx_q       <= rec_idx_d;
         term_cnt_q      <= term_cnt_d;
         run_cnt_q       <= run_cnt_d;
         pkt_rec_count_q <= pkt_rec_count_d;
         pkt_done_q      <= pkt_done_d;
      end
   end

   // Output drive; the write strobe follows fifo_full directly so no write is
   // ever issued into a full FIFO.
   always_comb begin
      s_axis_tready = tready_s;
      in_fifo_en    = wr_s;
      case (state_q)
         ST_EMIT: in_fifo_data = beat_q[C_SORTER_BIT_WIDTH-1:0];
         ST_TERM: in_fifo_data = C_TERM_VALUE;
         default: in_fifo_data = '0;
      endcase
      pkt_done      = pkt_done_q;
      pkt_rec_count = pkt_rec_count_q;
      busy          = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_axis_record_unpacker.sv
// -----------------------------------------------------------------------------
// tb_axis_record_unpacker
//
// Directed bench for axis_record_unpacker. Instance A uses one zero terminator,
// instance B uses three 32'hFFFFFFFF terminators. Written records and pkt_done
// values are collected on the falling edge and compared with hand-built
// expected sequences.
// -----------------------------------------------------------------------------
module tb_axis_record_unpacker;

   localparam int W  = 512;
   localparam int S  = 32;
   localparam int KW = W / 8;

   logic           clk;
   logic           rst_n;
   logic           tvalid_a, tvalid_b;
   logic           tready_a, tready_b;
   logic [W-1:0]   tdata;
   logic [KW-1:0]  tkeep;
   logic           tlast;
   logic           fifo_full;
   logic [S-1:0]   data_a, data_b;
   logic           en_a, en_b;
   logic           done_a, done_b;
   logic [31:0]    cnt_a, cnt_b;
   logic           busy_a, busy_b;

   int             n_cmp = 0;
   int             n_err = 0;
   logic           toggle_en;
   int             cyc = 0;
   int             viol_a = 0;
   int             viol_b = 0;
   int             trdy_a = 0;
   logic [31:0]    wq_a[$];
   logic [31:0]    wq_b[$];
   logic [31:0]    dq_a[$];
   logic [31:0]    dq_b[$];
   int             wcyc_a[$];
   logic [31:0]    exp_q[$];

   axis_record_unpacker #(
      .C_AXIS_TDATA_WIDTH (W),
      .C_SORTER_BIT_WIDTH (S),
      .C_TERM_RECORDS     (1),
      .C_TERM_VALUE       (32'h0000_0000),
      .C_CNT_WIDTH        (32)
   ) dut_a (
      .s_axis_aclk    (clk),
      .s_axis_aresetn (rst_n),
      .s_axis_tvalid  (tvalid_a),
      .s_axis_tready  (tready_a),
      .s_axis_tdata   (tdata),
      .s_axis_tkeep   (tkeep),
      .s_axis_tlast   (tlast),
      .fifo_full      (fifo_full),
      .in_fifo_data   (data_a),
      .in_fifo_en     (en_a),
      .pkt_done       (done_a),
      .pkt_rec_count  (cnt_a),
      .busy           (busy_a)
   );

   axis_record_unpacker #(
      .C_AXIS_TDATA_WIDTH (W),
      .C_SORTER_BIT_WIDTH (S),
      .C_TERM_RECORDS     (3),
      .C_TERM_VALUE       (32'hFFFF_FFFF),
      .C_CNT_WIDTH        (32)
   ) dut_b (
      .s_axis_aclk    (clk),
      .s_axis_aresetn (rst_n),
      .s_axis_tvalid  (tvalid_b),
      .s_axis_tready  (tready_b),
      .s_axis_tdata   (tdata),
      .s_axis_tkeep   (tkeep),
      .s_axis_tlast   (tlast),
      .fifo_full      (fifo_full),
      .in_fifo_data   (data_b),
      .in_fifo_en     (en_b),
      .pkt_done       (done_b),
      .pkt_rec_count  (cnt_b),
      .busy           (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect writes, done pulses, full-write violations and in-packet tready.
   always @(negedge clk) begin
      if (en_a) begin
         wq_a.push_back(data_a);
         wcyc_a.push_back(cyc);
      end
      if (en_b) wq_b.push_back(data_b);
      if (done_a) dq_a.push_back(cnt_a);
      if (done_b) dq_b.push_back(cnt_b);
      if (en_a && fifo_full) viol_a <= viol_a + 1;
      if (en_b && fifo_full) viol_b <= viol_b + 1;
      if (busy_a && tready_a) trdy_a <= trdy_a + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_beat(input int base);
      logic [W-1:0] d;
      for (int i = 0; i < W / S; i++) d[i*S +: S] = 32'(base + i);
      return d;
   endfunction

   task automatic send_pkt(input int sel, input int nb, input int base,
                           input logic [KW-1:0] last_keep, input logic end_pkt);
      logic ok;
      for (int b = 0; b < nb; b++) begin
         tdata = mk_beat(base + 16 * b);
         tlast = end_pkt && (b == nb - 1);
         tkeep = tlast ? last_keep : {KW{1'b1}};
         if (sel == 0) tvalid_a = 1'b1; else tvalid_b = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if ((sel == 0) ? tready_a : tready_b) ok = 1'b1;
         end
         check_eq("beat_accept", {63'd0, ok}, 64'd1);
         @(posedge clk);
         #1;
      end
      tvalid_a = 1'b0;
      tvalid_b = 1'b0;
      tlast    = 1'b0;
   endtask

   task automatic wait_writes(input int sel, input int start, input int n);
      int got;
      got = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         got = ((sel == 0) ? wq_a.size() : wq_b.size()) - start;
         if (got >= n) break;
      end
      check_eq("writes_seen", 64'((got >= n) ? n : got), 64'(n));
   endtask

   task automatic wait_done(input int sel, input int d0);
      int got;
      got = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         got = ((sel == 0) ? dq_a.size() : dq_b.size()) - d0;
         if (got > 0) break;
      end
      repeat (2) @(posedge clk);
      #1;
      got = ((sel == 0) ? dq_a.size() : dq_b.size()) - d0;
      check_eq("done_pulses", 64'(got), 64'd1);
   endtask

   task automatic check_seq(input int sel, input int start, input string tag);
      int sz;
      logic [31:0] v;
      sz = ((sel == 0) ? wq_a.size() : wq_b.size()) - start;
      check_eq({tag, "_len"}, 64'(sz), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         v = 32'hDEAD_BEEF;
         if (i < sz) v = (sel == 0) ? wq_a[start + i] : wq_b[start + i];
         check_eq($sformatf("%s[%0d]", tag, i), {32'd0, v}, {32'd0, exp_q[i]});
      end
   endtask

   initial begin
      int s0, s1, d0, t0, v0, span;
      rst_n     = 1'b0;
      tvalid_a  = 1'b0;
      tvalid_b  = 1'b0;
      tdata     = '0;
      tkeep     = '0;
      tlast     = 1'b0;
      fifo_full = 1'b0;
      toggle_en = 1'b0;

      fork
         begin
            int tc;
            tc = 0;
            forever begin
               @(posedge clk);
               #1;
               if (toggle_en) begin
                  tc++;
                  if (tc == 3) begin
                     fifo_full = ~fifo_full;
                     tc = 0;
                  end
               end else begin
                  tc = 0;
               end
            end
         end
      join_none

      // reset state
      repeat (2) @(negedge clk);
      check_eq("rst_tready_a", {63'd0, tready_a}, 64'd1);
      check_eq("rst_tready_b", {63'd0, tready_b}, 64'd1);
      check_eq("rst_en_a", {63'd0, en_a}, 64'd0);
      check_eq("rst_busy_a", {63'd0, busy_a}, 64'd0);
      check_eq("rst_done_a", {63'd0, done_a}, 64'd0);
      check_eq("rst_count_a", {32'd0, cnt_a}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // three full beats, FIFO never full
      s0 = wq_a.size(); d0 = dq_a.size(); t0 = trdy_a;
      send_pkt(0, 3, 0, {KW{1'b1}}, 1'b1);
      wait_done(0, d0);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(32'(i));
      exp_q.push_back(32'h0);
      check_seq(0, s0, "t1");
      check_eq("t1_count", {32'd0, dq_a[d0]}, 64'd48);
      check_eq("t1_tready_in_pkt", 64'(trdy_a - t0), 64'd2);
      span = (wcyc_a.size() >= s0 + 49) ? (wcyc_a[s0 + 48] - wcyc_a[s0]) : -1;
      check_eq("t1_no_bubble", 64'(span), 64'd48);

      // same packet with fifo_full toggling every 3 cycles
      s0 = wq_a.size(); d0 = dq_a.size(); t0 = trdy_a; v0 = viol_a;
      toggle_en = 1'b1;
      send_pkt(0, 3, 0, {KW{1'b1}}, 1'b1);
      wait_done(0, d0);
      toggle_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      fifo_full = 1'b0;
      check_seq(0, s0, "t2");
      check_eq("t2_count", {32'd0, dq_a[d0]}, 64'd48);
      check_eq("t2_tready_in_pkt", 64'(trdy_a - t0), 64'd2);
      check_eq("t2_write_while_full", 64'(viol_a - v0), 64'd0);

      // tlast beat with tkeep all zero: terminator only
      s0 = wq_a.size(); d0 = dq_a.size();
      send_pkt(0, 1, 500, {KW{1'b0}}, 1'b1);
      wait_done(0, d0);
      exp_q.delete();
      exp_q.push_back(32'h0);
      check_seq(0, s0, "t3_empty");
      check_eq("t3_empty_count", {32'd0, dq_a[d0]}, 64'd0);

      // tlast beat keeping records 0-3; kept bytes after the gap are ignored
      s0 = wq_a.size(); d0 = dq_a.size();
      send_pkt(0, 1, 100, 64'h0000_0000_003E_FFFF, 1'b1);
      wait_done(0, d0);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(100 + i));
      exp_q.push_back(32'h0);
      check_seq(0, s0, "t3_part");
      check_eq("t3_part_count", {32'd0, dq_a[d0]}, 64'd4);

      // three all-ones terminators, stalled by fifo_full inside TERM
      s0 = wq_b.size(); d0 = dq_b.size(); v0 = viol_b;
      send_pkt(1, 1, 200, {KW{1'b1}}, 1'b1);
      wait_writes(1, s0, 17);
      @(posedge clk);
      #1;
      fifo_full = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("t4_busy_in_stall", {63'd0, busy_b}, 64'd1);
      fifo_full = 1'b0;
      wait_done(1, d0);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(32'(200 + i));
      for (int i = 0; i < 3; i++) exp_q.push_back(32'hFFFF_FFFF);
      check_seq(1, s0, "t4");
      check_eq("t4_count", {32'd0, dq_b[d0]}, 64'd16);
      check_eq("t4_write_while_full", 64'(viol_b - v0), 64'd0);

      // reset after five records of a beat, then a fresh packet
      s0 = wq_a.size(); d0 = dq_a.size();
      send_pkt(0, 1, 300, {KW{1'b1}}, 1'b0);
      wait_writes(0, s0, 5);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq($sformatf("t5_en_in_reset%0d", k), {63'd0, en_a}, 64'd0);
      end
      check_eq("t5_busy_in_reset", {63'd0, busy_a}, 64'd0);
      check_eq("t5_count_in_reset", {32'd0, cnt_a}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      s1 = wq_a.size();
      check_eq("t5_recs_before_reset", 64'(s1 - s0), 64'd5);
      send_pkt(0, 1, 400, {KW{1'b1}}, 1'b1);
      wait_done(0, d0);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(32'(400 + i));
      exp_q.push_back(32'h0);
      check_seq(0, s1, "t5");
      check_eq("t5_count", {32'd0, dq_a[d0]}, 64'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
